// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin packet arbiter in front of the UART TX byte stream.
// A grant is held until the owner's last byte or MAX_BURST bytes, and a
// one-entry registered output stage sits between the requesters and the UART.
module uart_tx_arb #(
    parameter int unsigned REQ_NUM   = 4,
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned BURST_W   = $clog2(MAX_BURST + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [REQ_NUM*DATA_W-1:0]   req_data_i,
    input  logic [REQ_NUM-1:0]          req_vld_i,
    input  logic [REQ_NUM-1:0]          req_last_i,
    output logic [REQ_NUM-1:0]          req_rdy_o,
    output logic [DATA_W-1:0]           tx_data_o,
    output logic                        tx_vld_o,
    input  logic                        tx_rdy_i,
    output logic [REQ_NUM-1:0]          grant_o,
    output logic                        busy_o
);

    localparam int unsigned PTR_W = $clog2(REQ_NUM);

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t               state;
    logic [PTR_W-1:0]     ptr;
    logic [PTR_W-1:0]     owner;
    logic [BURST_W-1:0]   beat_cnt;

    logic [PTR_W-1:0]     sel;
    logic                 found;
    logic [DATA_W-1:0]    owner_data;
    logic                 out_free;
    logic                 accept;
    logic                 last_beat;

    // Round-robin scan starting at ptr; first valid requester wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            logic [PTR_W-1:0] cand;
            cand = PTR_W'((32'(ptr) + i) % REQ_NUM);
            if (!found && req_vld_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    // Select the current owner's data byte from the flattened bus.
    always_comb begin
        owner_data = '0;
        for (int unsigned k = 0; k < REQ_NUM; k++) begin
            if (PTR_W'(k) == owner) begin
                owner_data = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign out_free  = !tx_vld_o || tx_rdy_i;
    assign accept    = (state == LOCK) && req_vld_i[owner] && out_free;
    assign last_beat = req_last_i[owner] || (beat_cnt == BURST_W'(MAX_BURST - 1));
    assign req_rdy_o = ((state == LOCK) && out_free) ? grant_o : '0;
    assign busy_o    = (state == LOCK) || tx_vld_o;

    // Arbitration FSM, beat counter and registered output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            owner     <= '0;
            beat_cnt  <= '0;
            grant_o   <= '0;
            tx_data_o <= '0;
            tx_vld_o  <= 1'b0;
        end else begin
            // Load on accept; otherwise drop valid once the UART takes the byte.
            if (accept) begin
                tx_data_o <= owner_data;
                tx_vld_o  <= 1'b1;
            end else if (tx_rdy_i) begin
                tx_vld_o  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        owner   <= sel;
                        grant_o <= REQ_NUM'(1) << sel;
                        state   <= LOCK;
                    end
                end
                LOCK: begin
                    if (accept) begin
                        if (last_beat) begin
                            ptr      <= (owner == PTR_W'(REQ_NUM - 1)) ? '0 : owner + 1'b1;
                            beat_cnt <= '0;
                            grant_o  <= '0;
                            state    <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
